// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryptor: UNROLL rounds per clock, on-the-fly key schedule, valid/ready both sides.
// Latency 10/UNROLL cycles from acceptance to out_valid; holds the result in DONE until the sink takes it.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  // Entry a sits at bit 2047-8a, which is {~a, 3'b111}.
  assign y = TBL[{~a, 3'b111} -: 8];
endmodule

module aes_round (
  input  logic [127:0] st,
  input  logic [127:0] rk,
  input  logic [7:0]   rcon,
  input  logic         last,
  output logic [127:0] st_o,
  output logic [127:0] rk_o,
  output logic [7:0]   rcon_o
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0]  sb [16];
  logic [7:0]  sr [16];
  logic [7:0]  mc [16];
  logic [31:0] rot, sw, t, w0, w1, w2, w3;

  for (genvar i = 0; i < 16; i++) begin : g_byte
    aes_sbox u_sbox (.a(st[127-8*i -: 8]), .y(sb[i]));
    // Byte i is row i%4, column i/4; row r rotates left by r columns.
    assign sr[i] = sb[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
    assign st_o[127-8*i -: 8] = (last ? sr[i] : mc[i]) ^ rk_o[127-8*i -: 8];
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mc[4*c]   = xt(sr[4*c]) ^ xt(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+1] = sr[4*c] ^ xt(sr[4*c+1]) ^ xt(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xt(sr[4*c+2]) ^ xt(sr[4*c+3]) ^ sr[4*c+3];
    assign mc[4*c+3] = xt(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xt(sr[4*c+3]);
  end

  assign rot = {rk[23:0], rk[31:24]};
  for (genvar j = 0; j < 4; j++) begin : g_key
    aes_sbox u_ksbox (.a(rot[31-8*j -: 8]), .y(sw[31-8*j -: 8]));
  end

  assign t      = sw ^ {rcon, 24'h000000};
  assign w0     = rk[127:96] ^ t;
  assign w1     = rk[95:64] ^ w0;
  assign w2     = rk[63:32] ^ w1;
  assign w3     = rk[31:0] ^ w2;
  assign rk_o   = {w0, w1, w2, w3};
  assign rcon_o = xt(rcon);
endmodule

module aes128_iter_core #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  input  logic         in_key_keep,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
    $error("aes128_iter_core: UNROLL must be 1, 2, 5 or 10");
  end

  localparam logic [3:0] STEP = 4'(UNROLL);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [127:0] st, rk, key_q, key_sel;
  logic [7:0]   rcon;
  logic [3:0]   cnt;
  logic         last_step;

  logic [127:0] st_c   [UNROLL+1];
  logic [127:0] rk_c   [UNROLL+1];
  logic [7:0]   rcon_c [UNROLL+1];

  assign st_c[0]   = st;
  assign rk_c[0]   = rk;
  assign rcon_c[0] = rcon;

  for (genvar g = 0; g < UNROLL; g++) begin : g_rnd
    aes_round u_round (
      .st    (st_c[g]),
      .rk    (rk_c[g]),
      .rcon  (rcon_c[g]),
      .last  (cnt + 4'(g + 1) == 4'd10),
      .st_o  (st_c[g+1]),
      .rk_o  (rk_c[g+1]),
      .rcon_o(rcon_c[g+1])
    );
  end

  assign last_step = (cnt + STEP == 4'd10);
  assign key_sel   = in_key_keep ? key_q : in_key;
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st        <= '0;
      rk        <= '0;
      key_q     <= '0;
      rcon      <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          st   <= in_data ^ key_sel;
          rk   <= key_sel;
          rcon <= 8'h01;
          cnt  <= '0;
          if (!in_key_keep) key_q <= in_key;
        end
        RUN: begin
          st   <= st_c[UNROLL];
          rk   <= rk_c[UNROLL];
          rcon <= rcon_c[UNROLL];
          cnt  <= cnt + STEP;
          if (last_step) begin
            out_data  <= st_c[UNROLL];
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule
